// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master
// Description : Single-outstanding AXI4-Lite master bridging a simple command/
//               response port onto AR/R/AW/W/B. Optional transaction counters
//               are enabled by defining AXI_MASTER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int SWIDTH = DWIDTH / 8
) (
    input  logic              i_aClk,
    input  logic              i_aResetn,
    input  logic              i_cmdValid,
    output logic              o_cmdReady,
    input  logic              i_cmdWrite,
    input  logic [AWIDTH-1:0] i_cmdAddr,
    input  logic [DWIDTH-1:0] i_cmdData,
    input  logic [SWIDTH-1:0] i_cmdStrb,
    input  logic [2:0]        i_cmdProt,
    output logic              o_rspValid,
    input  logic              i_rspReady,
    output logic [DWIDTH-1:0] o_rspData,
    output logic [1:0]        o_rspResp,
    output logic              o_arValid,
    input  logic              i_arReady,
    output logic [AWIDTH-1:0] o_arAddr,
    output logic [2:0]        o_arProt,
    input  logic              i_rValid,
    output logic              o_rReady,
    input  logic [DWIDTH-1:0] i_rData,
    input  logic [1:0]        i_rResp,
    output logic              o_awValid,
    input  logic              i_awReady,
    output logic [AWIDTH-1:0] o_awAddr,
    output logic [2:0]        o_awProt,
    output logic              o_wValid,
    input  logic              i_wReady,
    output logic [DWIDTH-1:0] o_wData,
    output logic [SWIDTH-1:0] o_wStrb,
    input  logic              i_bValid,
    output logic              o_bReady,
    input  logic [1:0]        i_bResp,
    output logic [15:0]       o_wrCount,
    output logic [15:0]       o_rdCount
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } state_t;

    state_t              r_state, w_nextState;
    logic                r_cmdReady, r_awValid, r_wValid, r_bReady;
    logic                r_arValid, r_rReady, r_rspValid;
    logic                w_nextCmdReady, w_nextAwValid, w_nextWValid, w_nextBReady;
    logic                w_nextArValid, w_nextRReady, w_nextRspValid;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wData, r_rspData;
    logic [SWIDTH-1:0]   r_strb;
    logic [2:0]          r_prot;
    logic [1:0]          r_rspResp;
    logic                w_cmdAccept, w_bHs, w_rHs;

    assign w_cmdAccept = i_cmdValid && r_cmdReady;
    assign w_bHs       = (r_state == WRESP) && i_bValid && r_bReady;
    assign w_rHs       = (r_state == RDATA) && i_rValid && r_rReady;

    // Next-state and next-output logic; every output is a flop fed from here
    always_comb begin
        w_nextState    = r_state;
        w_nextCmdReady = r_cmdReady;
        w_nextAwValid  = r_awValid;
        w_nextWValid   = r_wValid;
        w_nextBReady   = r_bReady;
        w_nextArValid  = r_arValid;
        w_nextRReady   = r_rReady;
        w_nextRspValid = r_rspValid;
        case (r_state)
            IDLE: begin
                w_nextCmdReady = 1'b1;
                if (w_cmdAccept) begin
                    w_nextCmdReady = 1'b0;
                    if (i_cmdWrite) begin
                        w_nextState   = WRITE;
                        w_nextAwValid = 1'b1;
                        w_nextWValid  = 1'b1;
                    end else begin
                        w_nextState   = READ;
                        w_nextArValid = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (r_awValid && i_awReady) w_nextAwValid = 1'b0;
                if (r_wValid && i_wReady)   w_nextWValid  = 1'b0;
                if (!w_nextAwValid && !w_nextWValid) begin
                    w_nextState  = WRESP;
                    w_nextBReady = 1'b1;
                end
            end
            WRESP: begin
                if (w_bHs) begin
                    w_nextState    = RSP;
                    w_nextBReady   = 1'b0;
                    w_nextRspValid = 1'b1;
                end
            end
            READ: begin
                if (r_arValid && i_arReady) begin
                    w_nextState   = RDATA;
                    w_nextArValid = 1'b0;
                    w_nextRReady  = 1'b1;
                end
            end
            RDATA: begin
                if (w_rHs) begin
                    w_nextState    = RSP;
                    w_nextRReady   = 1'b0;
                    w_nextRspValid = 1'b1;
                end
            end
            RSP: begin
                if (r_rspValid && i_rspReady) begin
                    w_nextState    = IDLE;
                    w_nextRspValid = 1'b0;
                    w_nextCmdReady = 1'b1;
                end
            end
            default: begin
                w_nextState    = IDLE;
                w_nextCmdReady = 1'b0;
                w_nextAwValid  = 1'b0;
                w_nextWValid   = 1'b0;
                w_nextBReady   = 1'b0;
                w_nextArValid  = 1'b0;
                w_nextRReady   = 1'b0;
                w_nextRspValid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_aClk or negedge i_aResetn) begin
        if (!i_aResetn) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b0;
            r_awValid  <= 1'b0;
            r_wValid   <= 1'b0;
            r_bReady   <= 1'b0;
            r_arValid  <= 1'b0;
            r_rReady   <= 1'b0;
            r_rspValid <= 1'b0;
            r_addr     <= '0;
            r_wData    <= '0;
            r_strb     <= '0;
            r_prot     <= '0;
            r_rspData  <= '0;
            r_rspResp  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cmdReady <= w_nextCmdReady;
            r_awValid  <= w_nextAwValid;
            r_wValid   <= w_nextWValid;
            r_bReady   <= w_nextBReady;
            r_arValid  <= w_nextArValid;
            r_rReady   <= w_nextRReady;
            r_rspValid <= w_nextRspValid;
            if (w_cmdAccept) begin
                r_addr  <= i_cmdAddr;
                r_wData <= i_cmdData;
                r_strb  <= i_cmdStrb;
                r_prot  <= i_cmdProt;
            end
            // Response payload only changes on a slave handshake, so it holds through RSP
            if (w_bHs) begin
                r_rspData <= '0;
                r_rspResp <= i_bResp;
            end else if (w_rHs) begin
                r_rspData <= i_rData;
                r_rspResp <= i_rResp;
            end
        end
    end

`ifdef AXI_MASTER_STATS_EN
    logic [15:0] r_wrCount, r_rdCount;

    always_ff @(posedge i_aClk or negedge i_aResetn) begin
        if (!i_aResetn) begin
            r_wrCount <= '0;
            r_rdCount <= '0;
        end else begin
            if (w_bHs) r_wrCount <= r_wrCount + 16'd1;
            if (w_rHs) r_rdCount <= r_rdCount + 16'd1;
        end
    end

    assign o_wrCount = r_wrCount;
    assign o_rdCount = r_rdCount;
`else
    assign o_wrCount = 16'd0;
    assign o_rdCount = 16'd0;
`endif

    assign o_cmdReady = r_cmdReady;
    assign o_rspValid = r_rspValid;
    assign o_rspData  = r_rspData;
    assign o_rspResp  = r_rspResp;
    assign o_arValid  = r_arValid;
    assign o_arAddr   = r_addr;
    assign o_arProt   = r_prot;
    assign o_rReady   = r_rReady;
    assign o_awValid  = r_awValid;
    assign o_awAddr   = r_addr;
    assign o_awProt   = r_prot;
    assign o_wValid   = r_wValid;
    assign o_wData    = r_wData;
    assign o_wStrb    = r_strb;
    assign o_bReady   = r_bReady;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master
// Description : Randomised bench for axi_lite_master with a transaction-level
//               memory reference model and an AXI-Lite slave driven from tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          i_aClk = 1'b0;
    logic          i_aResetn;
    logic          i_cmdValid, o_cmdReady, i_cmdWrite;
    logic [AW-1:0] i_cmdAddr;
    logic [DW-1:0] i_cmdData;
    logic [SW-1:0] i_cmdStrb;
    logic [2:0]    i_cmdProt;
    logic          o_rspValid, i_rspReady;
    logic [DW-1:0] o_rspData;
    logic [1:0]    o_rspResp;
    logic          o_arValid, i_arReady;
    logic [AW-1:0] o_arAddr;
    logic [2:0]    o_arProt;
    logic          i_rValid, o_rReady;
    logic [DW-1:0] i_rData;
    logic [1:0]    i_rResp;
    logic          o_awValid, i_awReady;
    logic [AW-1:0] o_awAddr;
    logic [2:0]    o_awProt;
    logic          o_wValid, i_wReady;
    logic [DW-1:0] o_wData;
    logic [SW-1:0] o_wStrb;
    logic          i_bValid, o_bReady;
    logic [1:0]    i_bResp;
    logic [15:0]   o_wrCount, o_rdCount;

    int vectors = 0;
    int miscompares = 0;
    int refWr = 0;
    int refRd = 0;
    logic [31:0] refMem [logic [11:0]];
    logic [31:0] slvMem [logic [11:0]];

    always #5 i_aClk = ~i_aClk;

    axi_lite_master #(.AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW)) dut (
        .i_aClk(i_aClk), .i_aResetn(i_aResetn),
        .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady), .i_cmdWrite(i_cmdWrite),
        .i_cmdAddr(i_cmdAddr), .i_cmdData(i_cmdData), .i_cmdStrb(i_cmdStrb),
        .i_cmdProt(i_cmdProt), .o_rspValid(o_rspValid), .i_rspReady(i_rspReady),
        .o_rspData(o_rspData), .o_rspResp(o_rspResp),
        .o_arValid(o_arValid), .i_arReady(i_arReady), .o_arAddr(o_arAddr), .o_arProt(o_arProt),
        .i_rValid(i_rValid), .o_rReady(o_rReady), .i_rData(i_rData), .i_rResp(i_rResp),
        .o_awValid(o_awValid), .i_awReady(i_awReady), .o_awAddr(o_awAddr), .o_awProt(o_awProt),
        .o_wValid(o_wValid), .i_wReady(i_wReady), .o_wData(o_wData), .o_wStrb(o_wStrb),
        .i_bValid(i_bValid), .o_bReady(o_bReady), .i_bResp(i_bResp),
        .o_wrCount(o_wrCount), .o_rdCount(o_rdCount)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] memRead(input logic [11:0] a, input bit useRef);
        if (useRef) return refMem.exists(a) ? refMem[a] : 32'd0;
        return slvMem.exists(a) ? slvMem[a] : 32'd0;
    endfunction

    function automatic logic [15:0] expWrCount();
`ifdef AXI_MASTER_STATS_EN
        return 16'(refWr);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] expRdCount();
`ifdef AXI_MASTER_STATS_EN
        return 16'(refRd);
`else
        return 16'd0;
`endif
    endfunction

    task automatic issue_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot, output bit ok);
        int n;
        n = 0;
        @(negedge i_aClk);
        i_cmdValid = 1'b1; i_cmdWrite = wr; i_cmdAddr = addr;
        i_cmdData = data; i_cmdStrb = strb; i_cmdProt = prot;
        while (o_cmdReady !== 1'b1 && n < 20) begin
            @(negedge i_aClk);
            n++;
        end
        vectors++;
        if (o_cmdReady !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept_timeout: cmdReady=%b required 1", o_cmdReady);
            i_cmdValid = 1'b0;
            ok = 1'b0;
        end else begin
            @(negedge i_aClk);
            i_cmdValid = 1'b0;
            i_cmdData = $urandom;
            i_cmdAddr = 12'($urandom);
            ok = 1'b1;
            vectors++;
            if (o_cmdReady !== 1'b0) begin
                miscompares++;
                $display("FAIL cmd_ready_busy: cmdReady=%b required 0", o_cmdReady);
            end
            vectors++;
            if ({o_awValid, o_wValid, o_arValid} !== (wr ? 3'b110 : 3'b001)) begin
                miscompares++;
                $display("FAIL valid_latency: aw/w/ar=%b required %b",
                         {o_awValid, o_wValid, o_arValid}, (wr ? 3'b110 : 3'b001));
            end
        end
    endtask

    task automatic aw_slave(input int dly, input logic [11:0] addr, input logic [2:0] prot);
        for (int i = 0; i <= dly; i++) begin
            vectors++;
            if (o_awValid !== 1'b1 || o_awAddr !== addr || o_awProt !== prot) begin
                miscompares++;
                $display("FAIL aw_hold: valid=%b addr=%h prot=%h required 1 %h %h",
                         o_awValid, o_awAddr, o_awProt, addr, prot);
            end
            if (i < dly) @(negedge i_aClk);
        end
        i_awReady = 1'b1;
        @(negedge i_aClk);
        i_awReady = 1'b0;
        vectors++;
        if (o_awValid !== 1'b0) begin
            miscompares++;
            $display("FAIL aw_drop: awValid=%b required 0", o_awValid);
        end
    endtask

    task automatic w_slave(input int dly, input logic [31:0] data, input logic [3:0] strb);
        for (int i = 0; i <= dly; i++) begin
            vectors++;
            if (o_wValid !== 1'b1 || o_wData !== data || o_wStrb !== strb) begin
                miscompares++;
                $display("FAIL w_hold: valid=%b data=%h strb=%h required 1 %h %h",
                         o_wValid, o_wData, o_wStrb, data, strb);
            end
            if (i < dly) @(negedge i_aClk);
        end
        slvMem[o_awAddr] = merge(memRead(o_awAddr, 1'b0), o_wData, o_wStrb);
        i_wReady = 1'b1;
        @(negedge i_aClk);
        i_wReady = 1'b0;
        vectors++;
        if (o_wValid !== 1'b0) begin
            miscompares++;
            $display("FAIL w_drop: wValid=%b required 0", o_wValid);
        end
    endtask

    task automatic rsp_phase(input logic [31:0] expData, input logic [1:0] expResp, input int dly);
        for (int i = 0; i <= dly; i++) begin
            vectors++;
            if (o_rspValid !== 1'b1 || o_rspData !== expData || o_rspResp !== expResp ||
                o_cmdReady !== 1'b0 || o_bReady !== 1'b0 || o_rReady !== 1'b0) begin
                miscompares++;
                $display("FAIL rsp_hold: valid=%b data=%h resp=%h cmdRdy=%b b/r=%b%b required 1 %h %h 0 00",
                         o_rspValid, o_rspData, o_rspResp, o_cmdReady, o_bReady, o_rReady,
                         expData, expResp);
            end
            if (i < dly) @(negedge i_aClk);
        end
        i_rspReady = 1'b1;
        @(negedge i_aClk);
        i_rspReady = 1'b0;
        vectors++;
        if (o_rspValid !== 1'b0 || o_cmdReady !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_done: rspValid=%b cmdReady=%b required 0 1", o_rspValid, o_cmdReady);
        end
        vectors++;
        if (o_wrCount !== expWrCount() || o_rdCount !== expRdCount()) begin
            miscompares++;
            $display("FAIL counters: wr=%0d rd=%0d required %0d %0d",
                     o_wrCount, o_rdCount, expWrCount(), expRdCount());
        end
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int awDly, input int wDly, input int bDly,
                            input logic [1:0] resp, input int rspDly);
        bit ok;
        issue_cmd(1'b1, addr, data, strb, prot, ok);
        if (ok) begin
            fork
                aw_slave(awDly, addr, prot);
                w_slave(wDly, data, strb);
            join
            refMem[addr] = merge(memRead(addr, 1'b1), data, strb);
            for (int i = 0; i <= bDly; i++) begin
                vectors++;
                if (o_bReady !== 1'b1 || o_rspValid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wresp_wait: bReady=%b rspValid=%b required 1 0", o_bReady, o_rspValid);
                end
                if (i < bDly) @(negedge i_aClk);
            end
            i_bValid = 1'b1; i_bResp = resp;
            @(negedge i_aClk);
            i_bValid = 1'b0; i_bResp = ~resp;
            refWr++;
            rsp_phase(32'd0, resp, rspDly);
        end
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [2:0] prot, input int arDly,
                           input int rDly, input logic [1:0] resp, input int rspDly);
        bit ok;
        logic [31:0] exp;
        issue_cmd(1'b0, addr, $urandom, 4'($urandom), prot, ok);
        if (ok) begin
            for (int i = 0; i <= arDly; i++) begin
                vectors++;
                if (o_arValid !== 1'b1 || o_arAddr !== addr || o_arProt !== prot || o_rReady !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ar_hold: valid=%b addr=%h prot=%h rReady=%b required 1 %h %h 0",
                             o_arValid, o_arAddr, o_arProt, o_rReady, addr, prot);
                end
                if (i < arDly) @(negedge i_aClk);
            end
            i_arReady = 1'b1;
            @(negedge i_aClk);
            i_arReady = 1'b0;
            exp = memRead(addr, 1'b1);
            for (int i = 0; i <= rDly; i++) begin
                vectors++;
                if (o_arValid !== 1'b0 || o_rReady !== 1'b1 || o_rspValid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rdata_wait: arValid=%b rReady=%b rspValid=%b required 0 1 0",
                             o_arValid, o_rReady, o_rspValid);
                end
                if (i < rDly) @(negedge i_aClk);
            end
            i_rValid = 1'b1; i_rData = memRead(o_arAddr, 1'b0); i_rResp = resp;
            @(negedge i_aClk);
            i_rValid = 1'b0; i_rData = $urandom; i_rResp = ~resp;
            refRd++;
            rsp_phase(exp, resp, rspDly);
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic expCmdReady);
        vectors++;
        if ({o_cmdReady, o_awValid, o_wValid, o_arValid, o_bReady, o_rReady, o_rspValid} !==
            {expCmdReady, 6'b000000}) begin
            miscompares++;
            $display("FAIL %s: cmdRdy/aw/w/ar/b/r/rsp=%b required %b", name,
                     {o_cmdReady, o_awValid, o_wValid, o_arValid, o_bReady, o_rReady, o_rspValid},
                     {expCmdReady, 6'b000000});
        end
    endtask

    task automatic test_reset();
        i_aResetn = 1'b0;
        i_cmdValid = 0; i_cmdWrite = 0; i_cmdAddr = 0; i_cmdData = 0; i_cmdStrb = 0; i_cmdProt = 0;
        i_rspReady = 0; i_arReady = 0; i_rValid = 0; i_rData = 0; i_rResp = 0;
        i_awReady = 0; i_wReady = 0; i_bValid = 0; i_bResp = 0;
        repeat (3) @(negedge i_aClk);
        check_idle_outputs("reset_outputs", 1'b0);
        vectors++;
        if (o_rspData !== 32'd0 || o_rspResp !== 2'd0 || o_awAddr !== 12'd0 ||
            o_wData !== 32'd0 || o_wrCount !== 16'd0 || o_rdCount !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_data: rspData=%h resp=%h addr=%h wdata=%h wr=%0d rd=%0d required all 0",
                     o_rspData, o_rspResp, o_awAddr, o_wData, o_wrCount, o_rdCount);
        end
        i_aResetn = 1'b1;
        @(negedge i_aClk);
        check_idle_outputs("reset_release", 1'b1);
        i_bValid = 1'b1; i_rValid = 1'b1; i_rData = 32'hDEAD_BEEF; i_bResp = 2'd2;
        repeat (2) @(negedge i_aClk);
        i_bValid = 1'b0; i_rValid = 1'b0;
        check_idle_outputs("idle_ignores_b_r", 1'b1);
    endtask

    task automatic test_write_basic();
        do_write(12'h010, 32'h0000_00A5, 4'hF, 3'd0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic test_write_skew();
        do_write(12'h020, 32'h1234_5678, 4'hF, 3'd2, 0, 3, 1, 2'b00, 1);
    endtask

    task automatic test_read_basic();
        vectors++;
        if (memRead(12'h010, 1'b1) !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL ref_seed: model=%h required 000000a5", memRead(12'h010, 1'b1));
        end
        do_read(12'h010, 3'd1, 0, 0, 2'b00, 0);
    endtask

    task automatic test_decerr_hold();
        do_read(12'hFFC, 3'd0, 1, 2, 2'b11, 4);
        do_write(12'h030, 32'hCAFE_F00D, 4'b0101, 3'd7, 2, 0, 0, 2'b10, 2);
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom_range(0, 3));
            else
                do_read(a, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                        2'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_wresp();
        bit ok;
        issue_cmd(1'b1, 12'h040, 32'h0BAD_F00D, 4'hF, 3'd0, ok);
        if (ok) begin
            fork
                aw_slave(0, 12'h040, 3'd0);
                w_slave(1, 32'h0BAD_F00D, 4'hF);
            join
            refMem[12'h040] = 32'h0BAD_F00D;
            vectors++;
            if (o_bReady !== 1'b1) begin
                miscompares++;
                $display("FAIL wresp_entry: bReady=%b required 1", o_bReady);
            end
            i_aResetn = 1'b0;
            #1;
            check_idle_outputs("reset_in_wresp", 1'b0);
            refWr = 0;
            refRd = 0;
            i_bValid = 1'b1; i_bResp = 2'b00;
            @(negedge i_aClk);
            @(negedge i_aClk);
            i_aResetn = 1'b1;
            @(negedge i_aClk);
            i_bValid = 1'b0;
            check_idle_outputs("post_reset_release", 1'b1);
            repeat (3) @(negedge i_aClk);
            check_idle_outputs("abandoned_no_rsp", 1'b1);
            vectors++;
            if (o_wrCount !== 16'd0 || o_rdCount !== 16'd0) begin
                miscompares++;
                $display("FAIL reset_counters: wr=%0d rd=%0d required 0 0", o_wrCount, o_rdCount);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            do_write(12'(12'h080 + 4 * k), $urandom, 4'hF, 3'd0, 0, 0, 0, 2'b00, 0);
            do_read(12'(12'h080 + 4 * k), 3'd0, 0, 0, 2'b00, 0);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_skew();
        test_read_basic();
        test_decerr_hold();
        test_random(40);
        test_reset_wresp();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, meaning address width.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning data width.
REQ-003 SHALL have parameter SWIDTH, default DWIDTH/8, meaning write-strobe width.
REQ-004 SHALL have ports, in order (one clock; reset is asynchronous and active-low):
  i_aClk  in  1  clock;
  i_aResetn  in  1  async active-low reset;
  i_cmdValid  in  1  command valid;
  o_cmdReady  out  1  command accepted;
  i_cmdWrite  in  1  1=write, 0=read;
  i_cmdAddr  in  AWIDTH  address;
  i_cmdData  in  DWIDTH  write data;
  i_cmdStrb  in  SWIDTH  write strobes;
  i_cmdProt  in  3  Protection;
  o_rspValid  out  1  response valid;
  i_rspReady  in  1  response taken;
  o_rspData  out  DWIDTH  read data (0 for writes);
  o_rspResp  out  2  Response;
  o_arValid, i_arReady, o_arAddr, o_arProt  AR channel;
  i_rValid, o_rReady, i_rData, i_rResp  R channel;
  o_awValid, i_awReady, o_awAddr, o_awProt  AW channel;
  o_wValid, i_wReady, o_wData, o_wStrb  W channel;
  i_bValid, o_bReady, i_bResp  B channel;
  o_wrCount  out  16  completed writes;
  o_rdCount  out  16  completed reads.

Function
REQ-005 SHALL run an FSM with states IDLE, WRITE, WRESP, READ, RDATA, RSP; one transaction outstanding at a time.
REQ-006 SHALL assert o_cmdReady only in IDLE; a command is accepted when i_cmdValid && o_cmdReady.
REQ-007 SHALL register address, data, strobes and prot on acceptance; channel outputs SHALL be stable from valid assertion until handshake.
REQ-008 On a write accept SHALL go to WRITE and assert o_awValid and o_wValid the next cycle (1-cycle latency).
REQ-009 In WRITE SHALL track AW and W handshakes independently: each valid drops the cycle after its own handshake; both in the same cycle or in either order are legal.
REQ-010 SHALL leave WRITE for WRESP only after both AW and W have handshaken; o_bReady SHALL be 1 only in WRESP.
REQ-011 On a read accept SHALL go to READ, assert o_arValid next cycle, and move to RDATA after the AR handshake; o_rReady SHALL be 1 only in RDATA.
REQ-012 On B (or R) handshake SHALL capture i_bResp (or i_rData, i_rResp), enter RSP and assert o_rspValid the next cycle.
REQ-013 SHALL hold o_rspValid, o_rspData and o_rspResp stable until i_rspReady, then return to IDLE; earliest new acceptance is the following cycle.
REQ-014 SHALL never make any valid depend combinationally on its ready; all outputs are registered.
REQ-015 SHALL pass SLVERR/DECERR through on o_rspResp unchanged; no retry.
REQ-016 SHALL ignore i_bValid/i_rValid outside WRESP/RDATA.

Reset
REQ-017 SHALL reset asynchronously on i_aResetn low: FSM to IDLE, all valids/readies 0 (o_cmdReady 1 after release), data/addr/resp/counters 0.
REQ-018 Reset mid-transaction SHALL abandon it; no response SHALL be issued for it.

Configuration
REQ-019 With AXI_MASTER_STATS_EN defined SHALL increment o_wrCount on each B handshake and o_rdCount on each R handshake, wrapping 0xFFFF->0x0000.
REQ-020 Without AXI_MASTER_STATS_EN the ports SHALL remain and be tied to 0.

Verification
REQ-021 Write 0x0000_00A5 to 0x010, strobe 0xF, slave ready immediately -> AW/W valid 1 cycle after accept, rsp OKAY, data 0.
REQ-022 Write with i_wReady 3 cycles after i_awReady -> o_awValid drops after its handshake, o_wValid held 3 cycles, single B accepted.
REQ-023 Read 0x010 after REQ-021, slave returns 0x0000_00A5 -> o_rspData 0x0000_00A5, o_rspResp OKAY.
REQ-024 Slave returns DECERR on read of 0xFFC, i_rspReady low 4 cycles -> o_rspValid/o_rspResp=DECERR held 4 cycles, o_cmdReady 0 throughout.
REQ-025 Reset asserted while in WRESP -> all valids 0 immediately, no rsp issued, o_cmdReady 1 after release.
REQ-026 With AXI_MASTER_STATS_EN, 65537 writes -> o_wrCount=1; without it -> 0.
